// File: rtl/deinterleaver.sv
// Block deinterleaver for the receive chain. A whole block of Ncbps coded bits
// is buffered in arrival (interleaved) order, then read back in deinterleaved
// order. Only one block is in flight at a time: fill, drain, then idle again.
module deinterleaver #(
  parameter int MAX_NCBPS = 1152
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] rate_id,
  input  logic [2:0] subchan_ct,
  input  logic       in_bit,
  input  logic       in_valid,
  output logic       in_ready,
  output logic       out_bit,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       out_last,
  output logic       cfg_err
);

  localparam int AW = $clog2(MAX_NCBPS + 1);

  typedef enum logic [1:0] {IDLE, FILL, DRAIN} stateType;

  stateType      r_state;
  stateType      w_stateNext;

  logic          r_buf [0:MAX_NCBPS-1];
  logic [AW-1:0] r_wrCnt;
  logic [AW-1:0] r_n;
  logic [AW-1:0] r_nDiv12;
  logic [1:0]    r_s;
  logic [AW-1:0] r_k;
  logic [3:0]    r_colCnt;
  logic [AW-1:0] r_rowCnt;
  logic [AW-1:0] r_rowBase;
  logic [1:0]    r_rowMod3;
  logic          r_outBit;
  logic          r_outValid;
  logic          r_outLast;
  logic          r_cfgErr;

  logic          w_cfgValid;
  logic [AW-1:0] w_unit;
  logic [AW-1:0] w_nDiv12Lookup;
  logic [AW-1:0] w_nLookup;
  logic [1:0]    w_sLookup;
  logic          w_inFire;
  logic          w_outFire;
  logic          w_fillDone;
  logic [AW-1:0] w_wrAddr;
  logic [AW-1:0] w_m;
  logic [AW-1:0] w_j;
  logic [1:0]    w_cMod3;
  logic [2:0]    w_dRaw;
  logic [1:0]    w_d;

  assign w_inFire   = in_valid & in_ready;
  assign w_outFire  = r_outValid & out_ready;
  assign w_fillDone = (r_wrCnt == r_n - AW'(1));
  assign w_wrAddr   = (r_state == IDLE) ? '0 : r_wrCnt;

  assign out_bit    = r_outBit;
  assign out_valid  = r_outValid;
  assign out_last   = r_outLast;
  assign cfg_err    = r_cfgErr;

  // Block-size lookup: N/12 is 1/2/4/6 scaled by the subchannel count, N = 12*(N/12).
  always_comb begin
    w_cfgValid = (subchan_ct <= 3'd4);
    w_unit     = AW'(1);
    w_sLookup  = 2'd1;
    case (rate_id)
      2'd0:    begin w_unit = AW'(1); w_sLookup = 2'd1; end
      2'd1:    begin w_unit = AW'(2); w_sLookup = 2'd1; end
      2'd2:    begin w_unit = AW'(4); w_sLookup = 2'd2; end
      default: begin w_unit = AW'(6); w_sLookup = 2'd3; end
    endcase
    w_nDiv12Lookup = w_cfgValid ? (w_unit << (3'd4 - subchan_ct)) : w_unit;
    w_nLookup      = (w_nDiv12Lookup << 3) + (w_nDiv12Lookup << 2);
  end

  // Next-state and input-ready decode; ready is also held low while cfg_err is
  // still high from an invalid code, so the two never disagree for a cycle.
  always_comb begin
    w_stateNext = r_state;
    in_ready    = 1'b0;
    case (r_state)
      IDLE: begin
        in_ready = w_cfgValid && !r_cfgErr;
        if (in_valid && in_ready) w_stateNext = FILL;
      end
      FILL: begin
        in_ready = 1'b1;
        if (in_valid && w_fillDone) w_stateNext = DRAIN;
      end
      DRAIN: begin
        if (r_outValid && out_ready && r_outLast) w_stateNext = IDLE;
      end
      default: w_stateNext = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_stateNext;
  end

  // Read address for the next output bit. With m = (N/12)*col + row, the term
  // floor(12m/N) is just col, and N is a multiple of s, so the permutation
  // reduces to a within-group rotation by (m - col) mod s. For 64-QAM N/12 is a
  // multiple of 3, so m mod 3 equals row mod 3, which is tracked as a counter.
  always_comb begin
    w_m = r_rowBase + r_rowCnt;
    case (r_colCnt)
      4'd0, 4'd3, 4'd6, 4'd9:  w_cMod3 = 2'd0;
      4'd1, 4'd4, 4'd7, 4'd10: w_cMod3 = 2'd1;
      default:                 w_cMod3 = 2'd2;
    endcase
    w_dRaw = {1'b0, r_rowMod3} + 3'd3 - {1'b0, w_cMod3};
    w_d    = (w_dRaw >= 3'd3) ? 2'(w_dRaw - 3'd3) : w_dRaw[1:0];
    case (r_s)
      2'd2:    w_j = {w_m[AW-1:1], w_m[0] ^ r_colCnt[0]};
      2'd3:    w_j = w_m - AW'(r_rowMod3) + AW'(w_d);
      default: w_j = w_m;
    endcase
  end

  // Bit buffer, written in arrival order; its contents need no reset.
  always_ff @(posedge clk) begin
    if (w_inFire) r_buf[w_wrAddr] <= in_bit;
  end

  // Fill counter, block parameters, output registers and read-order counters.
  // The counters always describe the bit that will be presented after the
  // current one, so the first bit (always buffer index 0) appears one cycle
  // after the last input handshake.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wrCnt    <= '0;
      r_n        <= '0;
      r_nDiv12   <= '0;
      r_s        <= 2'd1;
      r_k        <= '0;
      r_colCnt   <= 4'd0;
      r_rowCnt   <= '0;
      r_rowBase  <= '0;
      r_rowMod3  <= 2'd0;
      r_outBit   <= 1'b0;
      r_outValid <= 1'b0;
      r_outLast  <= 1'b0;
      r_cfgErr   <= 1'b0;
    end else begin
      r_cfgErr <= (w_stateNext == IDLE) && !w_cfgValid;
      case (r_state)
        IDLE: begin
          if (w_inFire) begin
            r_n      <= w_nLookup;
            r_nDiv12 <= w_nDiv12Lookup;
            r_s      <= w_sLookup;
            r_wrCnt  <= AW'(1);
          end
        end
        FILL: begin
          if (w_inFire) begin
            r_wrCnt <= r_wrCnt + AW'(1);
            if (w_fillDone) begin
              r_outValid <= 1'b1;
              r_outBit   <= r_buf[0];
              r_outLast  <= 1'b0;
              r_k        <= '0;
              r_colCnt   <= 4'd1;
              r_rowCnt   <= '0;
              r_rowBase  <= r_nDiv12;
              r_rowMod3  <= 2'd0;
            end
          end
        end
        DRAIN: begin
          if (w_outFire) begin
            if (r_outLast) begin
              r_outValid <= 1'b0;
              r_outLast  <= 1'b0;
              r_outBit   <= 1'b0;
              r_k        <= '0;
              r_wrCnt    <= '0;
            end else begin
              r_outBit  <= r_buf[w_j];
              r_k       <= r_k + AW'(1);
              r_outLast <= ((r_k + AW'(1)) == (r_n - AW'(1)));
              if (r_colCnt == 4'd11) begin
                r_colCnt  <= 4'd0;
                r_rowBase <= '0;
                r_rowCnt  <= r_rowCnt + AW'(1);
                r_rowMod3 <= (r_rowMod3 == 2'd2) ? 2'd0 : r_rowMod3 + 2'd1;
              end else begin
                r_colCnt  <= r_colCnt + 4'd1;
                r_rowBase <= r_rowBase + r_nDiv12;
              end
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_deinterleaver.sv
// Self-checking bench for the deinterleaver: directed cases plus randomized
// blocks over every rate/subchannel combination, checked against a model that
// evaluates the deinterleave permutation directly with integer arithmetic.
module tb_deinterleaver;

   logic       clk = 1'b0;
   logic       reset;
   logic [1:0] rate_id;
   logic [2:0] subchan_ct;
   logic       in_bit;
   logic       in_valid;
   logic       in_ready;
   logic       out_bit;
   logic       out_valid;
   logic       out_ready;
   logic       out_last;
   logic       cfg_err;

   int checkCount = 0;
   int passCount  = 0;

   logic txBits [0:1151];
   logic rxBits [0:1151];

   deinterleaver #(.MAX_NCBPS(1152)) dut (
      .clk        (clk),
      .reset      (reset),
      .rate_id    (rate_id),
      .subchan_ct (subchan_ct),
      .in_bit     (in_bit),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .out_bit    (out_bit),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_last   (out_last),
      .cfg_err    (cfg_err)
   );

   // Free-running clock.
   always #5 clk = ~clk;

   // Hard stop in case something hangs outside the bounded loops.
   initial begin
      #3000000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checkCount++;
      if (observed === expected) passCount++;
      else $display("[TB] FAIL %s: observed %0h, expected %0h", tag, observed, expected);
   endtask

   // Block size: base 12/24/48/72 times 2^(4-code).
   function automatic int blockSize(input int rate, input int sc);
      int base;
      case (rate)
         0:       base = 12;
         1:       base = 24;
         2:       base = 48;
         default: base = 72;
      endcase
      return base * (1 << (4 - sc));
   endfunction

   // s = ceil(Ncpc/2), Ncpc = 1/2/4/6.
   function automatic int groupSize(input int rate);
      int ncpc;
      case (rate)
         0:       ncpc = 1;
         1:       ncpc = 2;
         2:       ncpc = 4;
         default: ncpc = 6;
      endcase
      return (ncpc + 1) / 2;
   endfunction

   // Buffer index that output k must come from.
   function automatic int srcIndex(input int n, input int s, input int k);
      int m;
      m = (n / 12) * (k % 12) + k / 12;
      return s * (m / s) + ((m + n - (12 * m) / n) % s);
   endfunction

   // Drive one block of txBits into the DUT, with random in_valid gaps; an
   // optional alternate rate_id is driven for the second half of the block.
   task automatic applyStimulus(input int rate, input int sc, input int n, input int gapPct, input int altRate);
      int idx = 0;
      int cyc = 0;
      while (idx < n && cyc < n * 20 + 200) begin
         @(negedge clk);
         cyc++;
         rate_id    = (altRate >= 0 && idx >= n / 2) ? 2'(altRate) : 2'(rate);
         subchan_ct = 3'(sc);
         in_valid   = ($urandom_range(0, 99) >= gapPct);
         in_bit     = txBits[idx];
         #1;
         if (in_valid && in_ready) idx++;
      end
      checkOutput("send_count", idx, n);
      @(negedge clk);
      in_valid = 1'b0;
      checkOutput("first_out_valid", out_valid, 1);
   endtask

   // Collect a block with random out_ready, checking stalls, in_ready and
   // out_last on the way; stops early when stopAt output bits were taken.
   task automatic collectBlock(input int n, input int s, input int readyPct, input int stopAt);
      int k = 0;
      int cyc = 0;
      int dataErr = 0;
      int stallErr = 0;
      int readyErr = 0;
      int lastErr = 0;
      logic stalled = 1'b0;
      logic heldBit = 1'b0;
      logic heldLast = 1'b0;
      while (k < n && k != stopAt && cyc < n * 30 + 200) begin
         @(negedge clk);
         cyc++;
         if (in_ready !== 1'b0) readyErr++;
         if (stalled && (out_valid !== 1'b1 || out_bit !== heldBit || out_last !== heldLast)) stallErr++;
         in_valid  = 1'($urandom_range(0, 1));
         in_bit    = 1'($urandom_range(0, 1));
         out_ready = ($urandom_range(0, 99) < readyPct);
         stalled   = out_valid && !out_ready;
         heldBit   = out_bit;
         heldLast  = out_last;
         if (out_valid && out_ready) begin
            rxBits[k] = out_bit;
            if (out_last !== (k == n - 1)) lastErr++;
            k++;
         end
      end
      checkOutput("in_ready_in_drain", readyErr, 0);
      checkOutput("stall_stable", stallErr, 0);
      if (stopAt < 0) begin
         for (int i = 0; i < k; i++)
            if (rxBits[i] !== txBits[srcIndex(n, s, i)]) dataErr++;
         checkOutput("out_count", k, n);
         checkOutput("last_flag", lastErr, 0);
         checkOutput("data_order", dataErr, 0);
         @(negedge clk);
         out_ready = 1'b0;
         in_valid  = 1'b0;
         checkOutput("after_last_out_valid", out_valid, 0);
         checkOutput("after_last_in_ready", in_ready, 1);
      end
   endtask

   task automatic runRandomBlock(input int rate, input int sc, input int gapPct, input int readyPct, input int altRate);
      int n;
      n = blockSize(rate, sc);
      for (int i = 0; i < n; i++) txBits[i] = 1'($urandom_range(0, 1));
      applyStimulus(rate, sc, n, gapPct, altRate);
      collectBlock(n, groupSize(rate), readyPct, -1);
   endtask

   task automatic oneHotCase(input int rate, input int hotIdx, input int expK, input string tag);
      int n;
      int ones = 0;
      int pos = -1;
      n = blockSize(rate, 4);
      for (int i = 0; i < n; i++) txBits[i] = 1'b0;
      txBits[hotIdx] = 1'b1;
      applyStimulus(rate, 4, n, 0, -1);
      collectBlock(n, groupSize(rate), 100, -1);
      for (int i = 0; i < n; i++)
         if (rxBits[i] === 1'b1) begin
            ones++;
            pos = i;
         end
      checkOutput({tag, "_ones"}, ones, 1);
      checkOutput({tag, "_pos"}, pos, expK);
   endtask

   initial begin
      logic [11:0] pattern;
      logic [11:0] word;
      int          quiet;
      int          leaked;

      reset      = 1'b1;
      rate_id    = 2'd0;
      subchan_ct = 3'd4;
      in_bit     = 1'b0;
      in_valid   = 1'b0;
      out_ready  = 1'b0;
      repeat (3) @(negedge clk);
      checkOutput("rst_out_valid", out_valid, 0);
      checkOutput("rst_out_last", out_last, 0);
      checkOutput("rst_out_bit", out_bit, 0);
      checkOutput("rst_cfg_err", cfg_err, 0);
      checkOutput("rst_in_ready", in_ready, 1);
      reset = 1'b0;

      $display("[TB] identity block N=12");
      pattern = 12'hA5C;
      for (int i = 0; i < 12; i++) txBits[i] = pattern[i];
      applyStimulus(0, 4, 12, 0, -1);
      collectBlock(12, 1, 100, -1);
      word = '0;
      for (int i = 0; i < 12; i++) word[i] = rxBits[i];
      checkOutput("identity_word", word, 12'hA5C);

      $display("[TB] one-hot cases");
      oneHotCase(1, 2, 1, "qpsk_in2");
      oneHotCase(1, 1, 12, "qpsk_in1");
      oneHotCase(2, 5, 1, "qam16_in5");
      oneHotCase(2, 0, 0, "qam16_in0");

      $display("[TB] sweep of all rate/subchannel combinations");
      for (int r = 0; r < 4; r++)
         for (int c = 0; c < 5; c++)
            runRandomBlock(r, c, 10, 80, -1);

      $display("[TB] backpressure, back-to-back blocks");
      runRandomBlock(2, 4, 0, 50, -1);
      runRandomBlock(2, 4, 0, 50, -1);

      $display("[TB] reset during drain");
      for (int i = 0; i < 96; i++) txBits[i] = 1'($urandom_range(0, 1));
      applyStimulus(2, 3, 96, 0, -1);
      collectBlock(96, 2, 70, 10);
      @(negedge clk);
      out_ready = 1'b0;
      in_valid  = 1'b0;
      reset     = 1'b1;
      @(negedge clk);
      checkOutput("reset_out_valid", out_valid, 0);
      checkOutput("reset_in_ready", in_ready, 1);
      reset     = 1'b0;
      out_ready = 1'b1;
      quiet = 0;
      repeat (20) begin
         @(negedge clk);
         if (out_valid !== 1'b0) quiet++;
      end
      checkOutput("no_output_after_reset", quiet, 0);
      out_ready = 1'b0;
      runRandomBlock(2, 3, 10, 80, -1);

      $display("[TB] invalid subchannel code");
      @(negedge clk);
      rate_id    = 2'd1;
      subchan_ct = 3'd6;
      in_valid   = 1'b1;
      leaked     = 0;
      repeat (4) begin
         @(negedge clk);
         if (in_ready !== 1'b0) leaked++;
      end
      checkOutput("cfg_err_high", cfg_err, 1);
      checkOutput("cfg_in_ready_low", leaked, 0);
      in_valid = 1'b0;
      runRandomBlock(1, 4, 0, 100, -1);

      $display("[TB] rate change mid-fill");
      runRandomBlock(2, 4, 0, 100, 3);

      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule
